// File: rtl/aud_ctrl_pkg.sv
// Shared types and constants for the multi-slot audio record/playback controller.
package aud_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_READY      = 3'd1,
      S_REC        = 3'd2,
      S_REC_PAUSE  = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      MODE_NORMAL     = 2'b00,
      MODE_FAST       = 2'b01,
      MODE_SLOW_CONST = 2'b10,
      MODE_SLOW_LIN   = 2'b11
   } mode_t;

   localparam int unsigned N_KEYS   = 3;
   localparam int unsigned KEY_REC  = 0;
   localparam int unsigned KEY_PLAY = 1;
   localparam int unsigned KEY_STOP = 2;

endpackage

// File: rtl/key_release_det.sv
// Per-key 2-flop synchroniser followed by a one-cycle release-edge (low->high) detector.
module key_release_det #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] key_n,
   output logic [W-1:0] release_ev
);

   logic [W-1:0] sync1;
   logic [W-1:0] sync2;
   logic [W-1:0] prev;

   // Keys are active-low, so '1 means "released, nothing pending".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign release_ev = sync2 & ~prev;

endmodule

// File: rtl/aud_ctrl_multislot.sv
// Multi-slot record/playback controller: key events -> recorder/AudDSP command pulses,
// per-slot length table and slot address generation.
module aud_ctrl_multislot
   import aud_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int N_SLOTS = 4,
   parameter int SLOT_W  = $clog2(N_SLOTS),
   parameter int SPEED_W = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_init_done,
   input  logic [2:0]                i_key,
   input  logic [SLOT_W-1:0]         i_slot,
   input  logic [SPEED_W-1:0]        i_speed,
   input  logic [1:0]                i_mode,
   input  logic [ADDR_W-SLOT_W-1:0]  i_rec_offset,
   input  logic                      i_play_end,
   output logic                      o_rec_start,
   output logic                      o_rec_pause,
   output logic                      o_rec_stop,
   output logic                      o_play_start,
   output logic                      o_play_pause,
   output logic                      o_play_stop,
   output logic                      o_play_en,
   output logic                      o_sram_we,
   output logic [ADDR_W-1:0]         o_base_addr,
   output logic [ADDR_W-1:0]         o_end_addr,
   output logic [SPEED_W-1:0]        o_speed,
   output logic [1:0]                o_mode,
   output logic [N_SLOTS-1:0]        o_slot_valid,
   output logic [2:0]                o_state
);

   localparam int OFF_W = ADDR_W - SLOT_W;

   logic [N_KEYS-1:0] ev;
   logic              k_stop, k_play, k_rec, rec_full;
   state_t            state_q, state_n;
   mode_t             mode_q;
   logic [SLOT_W-1:0] slot_q;
   logic [OFF_W-1:0]  len_q [N_SLOTS];
   logic [ADDR_W-1:0] slot_base;
   logic rec_start_n, rec_pause_n, rec_stop_n, play_start_n, play_pause_n, play_stop_n;
   logic latch_n, store_n;

   key_release_det #(.W(N_KEYS)) u_keys (
      .clk        (i_clk),
      .rst        (i_rst),
      .key_n      (i_key),
      .release_ev (ev)
   );

   assign k_stop   = ev[KEY_STOP];
   assign k_play   = ev[KEY_PLAY] & ~ev[KEY_STOP];
   assign k_rec    = ev[KEY_REC] & ~ev[KEY_PLAY] & ~ev[KEY_STOP];
   assign rec_full = &i_rec_offset;

   always_comb begin
      state_n      = state_q;
      rec_start_n  = 1'b0;
      rec_pause_n  = 1'b0;
      rec_stop_n   = 1'b0;
      play_start_n = 1'b0;
      play_pause_n = 1'b0;
      play_stop_n  = 1'b0;
      latch_n      = 1'b0;
      store_n      = 1'b0;
      case (state_q)
         S_INIT:
            if (i_init_done) state_n = S_READY;
         S_READY:
            if (k_rec) begin
               state_n = S_REC;  rec_start_n = 1'b1;
            end else if (k_play && o_slot_valid[slot_q]) begin
               state_n = S_PLAY; play_start_n = 1'b1; latch_n = 1'b1;
            end
         S_REC:
            if (k_stop || rec_full) begin
               state_n = S_READY; rec_stop_n = 1'b1; store_n = 1'b1;
            end else if (k_rec) begin
               state_n = S_REC_PAUSE; rec_pause_n = 1'b1;
            end
         S_REC_PAUSE:
            if (k_stop) begin
               state_n = S_READY; rec_stop_n = 1'b1; store_n = 1'b1;
            end else if (k_rec) begin
               state_n = S_REC; rec_start_n = 1'b1;
            end
         S_PLAY:
            if (i_play_end || k_stop) begin
               state_n = S_READY; play_stop_n = 1'b1;
            end else if (k_play) begin
               state_n = S_PLAY_PAUSE; play_pause_n = 1'b1;
            end
         S_PLAY_PAUSE:
            if (k_stop) begin
               state_n = S_READY; play_stop_n = 1'b1;
            end else if (k_play) begin
               state_n = S_PLAY; play_start_n = 1'b1; latch_n = 1'b1;
            end
         default:
            state_n = S_READY;
      endcase
   end

   assign slot_base = ADDR_W'(slot_q) << OFF_W;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_INIT;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
         o_play_en    <= 1'b0;
         slot_q       <= '0;
         o_slot_valid <= '0;
         o_base_addr  <= '0;
         o_end_addr   <= '0;
         o_speed      <= SPEED_W'(1);
         mode_q       <= MODE_NORMAL;
         for (int unsigned i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
      end else begin
         state_q      <= state_n;
         o_rec_start  <= rec_start_n;
         o_rec_pause  <= rec_pause_n;
         o_rec_stop   <= rec_stop_n;
         o_play_start <= play_start_n;
         o_play_pause <= play_pause_n;
         o_play_stop  <= play_stop_n;
         o_play_en    <= (state_n == S_PLAY);
         // Only track i_slot while staying idle, so the slot checked for playback is the one used.
         if (state_q == S_READY && state_n == S_READY) slot_q <= i_slot;
         if (latch_n) begin
            o_speed <= (i_speed == '0) ? SPEED_W'(1) : i_speed;
            mode_q  <= mode_t'(i_mode);
         end
         if (store_n) begin
            len_q[slot_q]        <= i_rec_offset;
            o_slot_valid[slot_q] <= (i_rec_offset != '0);
         end
         o_base_addr <= slot_base;
         o_end_addr  <= slot_base + ADDR_W'(len_q[slot_q]);
      end
   end

   assign o_sram_we = (state_q == S_REC);
   assign o_mode    = mode_q;
   assign o_state   = state_q;

endmodule

// File: doc/aud_ctrl_multislot.md
Name: aud_ctrl_multislot

Overview:
- Top-level record/playback controller for the WM8731 audio path; successor of the single-buffer speed controller.
- Splits SRAM into N_SLOTS equal recording regions and keeps a per-slot length table.
- Turns raw push-keys into release events and drives the recorder and AudDSP with one-cycle start/pause/stop pulses.
- Latches the speed and interpolation mode at play start and at resume, and stops recording automatically when a slot region is full.

Parameters:
ADDR_W, 20, SRAM word-address width
N_SLOTS, 4, recording slots; power of two, at least 2
SLOT_W, $clog2(N_SLOTS), slot index width (derived)
SPEED_W, 4, speed factor width

Ports:
i_clk  in  1  control clock (AUD_BCLK domain)
i_rst  in  1  reset; asynchronous, active-high
i_init_done  in  1  I2C initialisation finished (level)
i_key  in  3  raw keys, active-low (pressed = 0); [0] record, [1] play/pause, [2] stop
i_slot  in  SLOT_W  requested slot index
i_speed  in  SPEED_W  requested speed factor
i_mode  in  2  00 normal, 01 fast, 10 slow-constant, 11 slow-linear
i_rec_offset  in  ADDR_W-SLOT_W  recorder word offset inside the current slot
i_play_end  in  1  AudDSP reached the slot end address (level)
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  recorder command pulses
o_play_start, o_play_pause, o_play_stop  out  1 each  AudDSP command pulses
o_play_en  out  1  AudPlayer enable
o_sram_we  out  1  write phase; high only in S_REC
o_base_addr  out  ADDR_W  active slot base address = slot << (ADDR_W-SLOT_W)
o_end_addr  out  ADDR_W  o_base_addr + stored length of the active slot
o_speed  out  SPEED_W  latched speed
o_mode  out  2  latched mode
o_slot_valid  out  N_SLOTS  per-slot "holds audio" flags
o_state  out  3  current FSM state code

Behaviour:
- Reset (async, i_rst=1):
  - state S_INIT; all pulses, o_play_en and o_sram_we are 0.
  - Active slot 0; length table and o_slot_valid cleared.
  - o_speed=1, o_mode=00.
  - Key latches set to "no press pending".
  - Any operation in progress is abandoned; no stop pulse is emitted.
- Key input:
  - 2-flop synchroniser per key.
  - Event = synchronised high after a registered low (release edge), lasting one cycle.
  - Same-cycle priority: stop > play > record; lower-priority events that cycle are discarded.
- Command outputs:
  - Every command output is registered and asserted for exactly one cycle, in the cycle after the triggering event.
  - The state changes in that same cycle.
- States and transitions:
  - S_INIT -> S_READY when i_init_done=1. Keys are ignored in S_INIT.
  - S_READY:
    - i_slot is sampled every cycle into the active slot.
    - K0 -> S_REC: rec_start.
    - K1 -> S_PLAY: play_start, latch speed/mode, o_play_en=1. Only when o_slot_valid[slot]=1; otherwise ignored and the state stays.
    - K2: no effect.
  - S_REC:
    - K0 -> S_REC_PAUSE: rec_pause.
    - K2 -> S_READY: rec_stop, store length.
    - Slot full (i_rec_offset = all ones) -> S_READY: rec_stop, store length = all ones.
  - S_REC_PAUSE:
    - K0 -> S_REC: rec_start.
    - K2 -> S_READY: rec_stop, store length.
  - S_PLAY:
    - K1 -> S_PLAY_PAUSE: play_pause, o_play_en=0.
    - K2 -> S_READY: play_stop, o_play_en=0.
    - i_play_end=1 -> S_READY: play_stop, o_play_en=0. If a key event occurs in the same cycle, i_play_end wins.
  - S_PLAY_PAUSE:
    - K1 -> S_PLAY: play_start, re-latch speed/mode, o_play_en=1.
    - K2 -> S_READY: play_stop.
- Length store:
  - length[slot] <= i_rec_offset at stop.
  - valid[slot] <= (i_rec_offset != 0). A zero-length recording clears valid.
- Slot lock: the active slot is frozen outside S_READY; i_slot changes there are ignored.
- Speed clamp: i_speed=0 latches as 1. Speed and mode never change mid-play.
- Address arithmetic:
  - o_end_addr is computed in ADDR_W bits and cannot overflow, because length fits the slot.
  - o_base_addr and o_end_addr are registered and update one cycle after a slot change.
- State codes: S_INIT=0, S_READY=1, S_REC=2, S_REC_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5. Codes 6-7 recover to S_READY.

Decomposition:
- Package aud_ctrl_pkg holds:
  - state enum (3-bit);
  - mode enum (normal, fast, slow_const, slow_lin);
  - key index constants KEY_REC=0, KEY_PLAY=1, KEY_STOP=2.
- Sub-module key_release_det, instantiated once with a width parameter of 3: synchroniser plus release-edge detect.
- The FSM and length table stay in the top module.

Test Plan:
- Reset/init: i_rst pulse, then i_init_done=1 -> o_state 0, then 1 next cycle; all pulses 0; o_slot_valid=0000.
- Record slot 2:
  - Setup: i_slot=2, release K0 -> rec_start pulse 1 cycle; o_base_addr=0x80000; o_sram_we=1.
  - Stop: set i_rec_offset=0x1234, release K2 -> rec_stop; o_slot_valid=0100; o_end_addr=0x81234.
- Play on empty slot: i_slot=1, release K1 -> no pulse; o_state stays 1.
- Play slot 2 with speed 0: i_speed=0, i_mode=10, release K1 -> play_start; o_speed=1, o_mode=10, o_play_en=1. Then assert i_play_end together with a K1 release -> play_stop only; o_state=1.
- Auto-stop and pause: record until i_rec_offset=0x3FFFF -> rec_stop; length=0x3FFFF. Pause/resume mid-record -> rec_pause then rec_start; o_state 2->3->2.
- Simultaneous keys and reset mid-play:
  - K1+K2 released in the same cycle during S_PLAY -> play_stop only.
  - i_rst asserted during S_PLAY -> o_play_en=0 immediately (async); o_slot_valid cleared.
